// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_W    : number of segment lines (A..G, bit0 = A)
//   NIB_W    : width of one hex digit value
//   SEG_LUT  : hex 0-F font, active-high segments
//   scan_state_e : per-slot scan phase (BLANK gap, then DRIVE)
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_LUT [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_driver_if.sv
// Bundle of the physical display lines.
//   seg[6:0]           : segment lines, bit0 = A .. bit6 = G
//   dp                 : decimal point line
//   digit_en[DIGITS-1:0] : digit common enables
// output_port is used by the controller, input_port by whatever observes it.
interface seg7_driver_if #(
  parameter int unsigned DIGITS = 3
);
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] digit_en;

  modport output_port (output seg, output dp, output digit_en);
  modport input_port  (input seg, input dp, input digit_en);
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-seven-segment decoder (active-high segments).
//   i_hex : 4-bit digit value
//   o_seg : segment pattern, bit0 = A .. bit6 = G
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] i_hex,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = SEG_LUT[i_hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment display scan controller.
// Digits are lit one at a time, each for SLOT_CYCLES clocks, with a dark gap of
// BLANK_CYCLES at the start of every slot. Updates are staged through a
// ready/valid handshake and moved into the displayed (shadow) copy only at the
// frame boundary, so a frame never mixes two updates.
//   clk, rst      : clock, synchronous active-high reset
//   hex_i         : digit values, digit i at [4i+3:4i], digit 0 rightmost
//   dp_i, mask_i  : per-digit decimal point request and lit enable
//   upd_valid     : hex_i/dp_i/mask_i valid for capture
//   upd_ready     : no update pending, capture possible
//   frame_start   : one-cycle pulse at the start of the digit-0 slot
//   disp          : seg/dp/digit_en display lines (registered)
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 3,
  parameter int unsigned SLOT_CYCLES   = 50000,
  parameter int unsigned BLANK_CYCLES  = 500,
  parameter int unsigned INVERT_DIGITS = 0,
  parameter int unsigned INVERT_SEGS   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NIB_W*DIGITS-1:0] hex_i,
  input  logic [DIGITS-1:0]       dp_i,
  input  logic [DIGITS-1:0]       mask_i,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  output logic                    frame_start,
  seg7_driver_if.output_port      disp
);

  localparam int unsigned CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0] CntMax   = CntW'(SLOT_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLim = CntW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(DIGITS - 1);

  // Idle (off / inactive) levels after polarity inversion.
  localparam logic [SEG_W-1:0]  SegIdle = (INVERT_SEGS != 0) ? {SEG_W{1'b1}} : '0;
  localparam logic              DpIdle  = (INVERT_SEGS != 0);
  localparam logic [DIGITS-1:0] EnIdle  = (INVERT_DIGITS != 0) ? {DIGITS{1'b1}} : '0;

  // Scan position and phase
  logic [CntW-1:0] r_cnt;
  logic [IdxW-1:0] r_idx;
  scan_state_e     r_state;

  // Staged and displayed copies of the update
  logic                    r_pending;
  logic [NIB_W*DIGITS-1:0] r_stg_hex, r_sh_hex;
  logic [DIGITS-1:0]       r_stg_dp, r_sh_dp;
  logic [DIGITS-1:0]       r_stg_mask, r_sh_mask;

  // Registered outputs
  logic [SEG_W-1:0]  r_seg;
  logic              r_dp;
  logic [DIGITS-1:0] r_digit_en;
  logic              r_frame_start;

  logic              w_cnt_wrap;
  logic [CntW-1:0]   w_cnt_nxt;
  logic              w_boundary;
  logic              w_accept;
  logic [NIB_W-1:0]  w_nib;
  logic              w_dp_sel;
  logic              w_mask_sel;
  logic [DIGITS-1:0] w_onehot;
  logic [SEG_W-1:0]  w_seg_raw;
  logic              w_lit;

  assign w_cnt_wrap = (r_cnt == CntMax);
  assign w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + CntW'(1);
  assign w_boundary = w_cnt_wrap && (r_idx == IdxMax);
  assign w_accept   = upd_valid && !r_pending;
  assign upd_ready  = !r_pending;

  // Select the shadow fields of the digit currently being scanned.
  always_comb begin
    w_nib      = '0;
    w_dp_sel   = 1'b0;
    w_mask_sel = 1'b0;
    w_onehot   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_nib       = r_sh_hex[NIB_W*i +: NIB_W];
        w_dp_sel    = r_sh_dp[i];
        w_mask_sel  = r_sh_mask[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seg7_hex_decoder u_dec (
    .i_hex (w_nib),
    .o_seg (w_seg_raw)
  );

  // A masked digit stays dark through its whole slot, exactly like BLANK.
  assign w_lit = (r_state == DRIVE) && w_mask_sel;

  // Scan FSM with registered display outputs. r_state tracks the phase of
  // r_cnt, so the outputs reflect the counter/index state one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_state       <= BLANK;
      r_seg         <= SegIdle;
      r_dp          <= DpIdle;
      r_digit_en    <= EnIdle;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_wrap) begin
        r_idx <= (r_idx == IdxMax) ? '0 : r_idx + IdxW'(1);
      end
      r_state <= (w_cnt_nxt < BlankLim) ? BLANK : DRIVE;

      case (r_state)
        DRIVE: begin
          r_seg      <= (w_lit ? w_seg_raw : '0) ^ SegIdle;
          r_dp       <= (w_lit && w_dp_sel) ^ DpIdle;
          r_digit_en <= (w_lit ? w_onehot : '0) ^ EnIdle;
        end
        default: begin
          r_seg      <= SegIdle;
          r_dp       <= DpIdle;
          r_digit_en <= EnIdle;
        end
      endcase

      r_frame_start <= (r_cnt == '0) && (r_idx == '0);
    end
  end

  // Update handshake. Accept needs !pending and the boundary copy needs
  // pending, so a value accepted on the boundary cycle waits a full frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_stg_hex  <= '0;
      r_stg_dp   <= '0;
      r_stg_mask <= '0;
      r_sh_hex   <= '0;
      r_sh_dp    <= '0;
      r_sh_mask  <= '0;
    end else if (w_boundary && r_pending) begin
      r_sh_hex  <= r_stg_hex;
      r_sh_dp   <= r_stg_dp;
      r_sh_mask <= r_stg_mask;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_stg_hex  <= hex_i;
      r_stg_dp   <= dp_i;
      r_stg_mask <= mask_i;
      r_pending  <= 1'b1;
    end
  end

  assign disp.seg      = r_seg;
  assign disp.dp       = r_dp;
  assign disp.digit_en = r_digit_en;
  assign frame_start   = r_frame_start;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 3: number of multiplexed digits, SHALL be >= 1.
REQ-002 Parameter SLOT_CYCLES, default 50000: clock cycles per digit time slot.
REQ-003 Parameter BLANK_CYCLES, default 500: anti-ghosting gap at each slot start, SHALL be < SLOT_CYCLES.
REQ-004 Parameter INVERT_DIGITS, default 0: 1 inverts digit_en, for common anode.
REQ-005 Parameter INVERT_SEGS, default 0: 1 inverts seg and dp, for common anode.
REQ-006 Port clk, input, 1: single clock; all logic on rising edge.
REQ-007 Port rst, input, 1: reset, synchronous, active-high.
REQ-008 Port hex_i, input, 4*DIGITS: digit values; digit i at [4i+3:4i], digit 0 rightmost.
REQ-009 Port dp_i, input, DIGITS: decimal point request per digit.
REQ-010 Port mask_i, input, DIGITS: 1 = digit lit, 0 = digit blanked.
REQ-011 Port upd_valid, input, 1: hex_i/dp_i/mask_i are valid for capture.
REQ-012 Port upd_ready, output, 1: controller can accept an update.
REQ-013 Port frame_start, output, 1: one-cycle pulse on the first cycle of the digit-0 slot.
REQ-014 Port disp, seg7_driver_if.output_port: drives seg[6:0] (bit0=A..bit6=G), dp, and digit_en[DIGITS-1:0].

Function
REQ-015 Update handshake: on a cycle with upd_valid && upd_ready, the inputs SHALL be captured into a staged register and the pending flag set; upd_ready SHALL equal !pending.
REQ-016 Frame boundary: the last cycle of the digit DIGITS-1 slot; at that cycle, if pending, staged SHALL copy to shadow and pending SHALL clear.
REQ-017 Tear-free display: the shown data SHALL come only from shadow, so one frame never mixes two updates.
REQ-018 Simultaneous accept and frame boundary cannot both act: the boundary SHALL act only when pending was already set; a value accepted on the boundary cycle SHALL apply at the next boundary.
REQ-019 Slot counter: SHALL count 0..SLOT_CYCLES-1 and wrap to 0.
REQ-020 Digit index: SHALL advance on counter wrap, modulo DIGITS, with DIGITS-1 -> 0.
REQ-021 FSM states: BLANK and DRIVE.
REQ-022 BLANK state: counter < BLANK_CYCLES; all digit_en inactive, seg and dp off.
REQ-023 DRIVE state: remaining cycles of the slot; digit_en one-hot at index, seg = decode(shadow hex[index]), dp = shadow dp[index].
REQ-024 A digit with shadow mask = 0 SHALL behave as BLANK for its whole slot; slot timing is unchanged.
REQ-025 Decode: SHALL use the standard hex 0-F font with active-high segments before inversion (0 -> 7'h3F, 8 -> 7'h7F, F -> 7'h71).
REQ-026 Inversion: applied at the output stage per INVERT_SEGS and INVERT_DIGITS; "off" and "inactive" mean the post-inversion idle level.
REQ-027 Latency: disp outputs and frame_start SHALL be registered, exactly 1 cycle after the counter/index state that selects them.

Reset
REQ-028 On rst, SHALL clear counter, index, pending and FSM state (to BLANK), and set shadow and staged to all zeros (mask 0).
REQ-029 Output reset values: seg/dp off, digit_en inactive, frame_start 0, upd_ready 1 on the first cycle after reset.
REQ-030 Reset asserted mid-frame SHALL take effect on the next edge; a pending update SHALL be discarded.

Structure
REQ-031 Package seg7_pkg SHALL hold the SEG_LUT 16x7 font constant, the scan state enum (BLANK, DRIVE), and the segment/digit width constants.
REQ-032 The combinational decode SHALL live in sub-module seg7_hex_decoder (4-bit in, 7-bit out, using SEG_LUT).

Verification (DIGITS=3, SLOT_CYCLES=8, BLANK_CYCLES=2, non-inverted)
REQ-033 Reset: assert rst for 2 cycles -> digit_en=3'b000, seg=7'h00, upd_ready=1; display stays dark until the first update.
REQ-034 Scan: update hex=12'h321, mask=3'b111 -> after the boundary:
  - digit_en 3'b001 with seg=7'h06 for 6 cycles, preceded by 2 blank cycles;
  - then digit 1 with 7'h5B, then digit 2 with 7'h4F;
  - frame_start every 24 cycles.
REQ-035 Handshake: second upd_valid while pending -> upd_ready=0, value not captured; upd_ready returns to 1 the cycle after the boundary.
REQ-036 Tear-free: change hex mid-frame to 12'hABC -> the current frame completes with the old values, and the next frame shows the new ones.
REQ-037 Mask and dp: mask=3'b101, dp=3'b100 -> digit 1 slot fully dark; dp=1 only in digit 2 DRIVE cycles.
REQ-038 Inversion and reset: INVERT_SEGS=1, INVERT_DIGITS=1 -> reset levels seg=7'h7F, digit_en=3'b111; rst mid-slot -> dark on the next cycle, index 0.
